// File: rtl/clkdiv_pkg.sv
// Shared constants for the clock divider bank: default widths, 5 MHz rate limits and
// a helper that packs per-channel default limits into one vector.
package clkdiv_pkg;

    localparam int unsigned DEF_CNT_W  = 23;
    localparam int unsigned DEF_NUM_CH = 3;

    // Half-period limits for a 5 MHz clock (half-period = limit + 1 cycles).
    localparam int unsigned LIM_500HZ = 4999;
    localparam int unsigned LIM_1P5HZ = 1666667;
    localparam int unsigned LIM_2S    = 4999999;

    function automatic logic [DEF_NUM_CH*DEF_CNT_W-1:0] build_default_limit(
        input int unsigned lim0,
        input int unsigned lim1,
        input int unsigned lim2
    );
        logic [DEF_NUM_CH*DEF_CNT_W-1:0] vec;
        vec = '0;
        vec[0*DEF_CNT_W +: DEF_CNT_W] = lim0[DEF_CNT_W-1:0];
        vec[1*DEF_CNT_W +: DEF_CNT_W] = lim1[DEF_CNT_W-1:0];
        vec[2*DEF_CNT_W +: DEF_CNT_W] = lim2[DEF_CNT_W-1:0];
        return vec;
    endfunction

    localparam logic [DEF_NUM_CH*DEF_CNT_W-1:0] DEF_LIMIT_VEC =
        build_default_limit(LIM_500HZ, LIM_1P5HZ, LIM_2S);

endpackage

// File: rtl/clkdiv_channel.sv
// One divider channel: half-period counter, active and pending limit, registered
// square output and rising-edge tick.
module clkdiv_channel
    import clkdiv_pkg::*;
#(
    parameter int unsigned      CNT_W         = DEF_CNT_W,
    parameter logic [CNT_W-1:0] DEFAULT_LIMIT = '0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             enable_i,
    input  logic             restart_i,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_value_i,
    output logic             clk_out_o,
    output logic             tick_o
);

    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] limit_q, limit_d;
    logic [CNT_W-1:0] pend_q, pend_d;
    logic             pend_v_q, pend_v_d;
    logic             clk_out_q, clk_out_d;
    logic             tick_q, tick_d;

    logic             wrap;
    logic [CNT_W-1:0] next_limit;

    assign wrap = enable_i && (count_q == limit_q);

    // A load coinciding with a wrap or restart bypasses the pending slot.
    assign next_limit = load_i ? load_value_i : (pend_v_q ? pend_q : limit_q);

    always_comb begin
        count_d   = count_q;
        limit_d   = limit_q;
        pend_d    = pend_q;
        pend_v_d  = pend_v_q;
        clk_out_d = clk_out_q;
        tick_d    = 1'b0;

        if (restart_i) begin
            count_d   = '0;
            clk_out_d = 1'b0;
            limit_d   = next_limit;
            pend_v_d  = 1'b0;
        end else if (wrap) begin
            count_d   = '0;
            clk_out_d = ~clk_out_q;
            tick_d    = ~clk_out_q;
            limit_d   = next_limit;
            pend_v_d  = 1'b0;
        end else begin
            if (enable_i) begin
                count_d = count_q + {{(CNT_W-1){1'b0}}, 1'b1};
            end
            if (load_i) begin
                pend_d   = load_value_i;
                pend_v_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q   <= '0;
            limit_q   <= DEFAULT_LIMIT;
            pend_q    <= '0;
            pend_v_q  <= 1'b0;
            clk_out_q <= 1'b0;
            tick_q    <= 1'b0;
        end else begin
            count_q   <= count_d;
            limit_q   <= limit_d;
            pend_q    <= pend_d;
            pend_v_q  <= pend_v_d;
            clk_out_q <= clk_out_d;
            tick_q    <= tick_d;
        end
    end

    assign clk_out_o = clk_out_q;
    assign tick_o    = tick_q;

endmodule

// File: rtl/clock_divider_bank.sv
// Multi-channel clock divider on the 5 MHz system clock; each channel is an
// independent clkdiv_channel with its own enable, restart and loadable limit.
module clock_divider_bank
    import clkdiv_pkg::*;
#(
    parameter int unsigned              NUM_CH        = DEF_NUM_CH,
    parameter int unsigned              CNT_W         = DEF_CNT_W,
    parameter logic [NUM_CH*CNT_W-1:0]  DEFAULT_LIMIT = DEF_LIMIT_VEC
) (
    input  logic              clk5MHz,
    input  logic              rst,
    input  logic [NUM_CH-1:0] enable,
    input  logic [NUM_CH-1:0] restart,
    input  logic [NUM_CH-1:0] load,
    input  logic [CNT_W-1:0]  load_value,
    output logic [NUM_CH-1:0] clk_out,
    output logic [NUM_CH-1:0] tick
);

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        clkdiv_channel #(
            .CNT_W        (CNT_W),
            .DEFAULT_LIMIT(DEFAULT_LIMIT[i*CNT_W +: CNT_W])
        ) u_channel (
            .clk_i       (clk5MHz),
            .rst_i       (rst),
            .enable_i    (enable[i]),
            .restart_i   (restart[i]),
            .load_i      (load[i]),
            .load_value_i(load_value),
            .clk_out_o   (clk_out[i]),
            .tick_o      (tick[i])
        );
    end

endmodule

// File: tb/tb_clock_divider_bank.sv
// Bench for clock_divider_bank: directed scenarios with literal timing checks, then
// random traffic, all compared every cycle against a half-period/level reference model.
module tb_clock_divider_bank;

    localparam int NCH = 3;
    localparam int CW  = 8;

    logic           clk = 1'b0;
    logic           rst;
    logic [NCH-1:0] enable, restart, load;
    logic [CW-1:0]  load_value;
    logic [NCH-1:0] clk_out, tick;

    int nvec = 0;
    int nerr = 0;

    clock_divider_bank #(
        .NUM_CH       (NCH),
        .CNT_W        (CW),
        .DEFAULT_LIMIT({8'd3, 8'd1, 8'd0})
    ) dut (
        .clk5MHz   (clk),
        .rst       (rst),
        .enable    (enable),
        .restart   (restart),
        .load      (load),
        .load_value(load_value),
        .clk_out   (clk_out),
        .tick      (tick)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        nvec++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: each channel is a level plus elapsed enabled cycles in the current
    // half-period of length m_half; tick is simply a rising edge of the level.
    int  def_lim [NCH] = '{0, 1, 3};
    int  m_half  [NCH];
    int  m_el    [NCH];
    int  m_pend  [NCH];
    bit  m_pv    [NCH];
    bit  m_lvl   [NCH];
    bit  m_tick  [NCH];
    bit  model_valid = 1'b0;

    always @(posedge clk) begin
        for (int c = 0; c < NCH; c++) begin
            int nxt_half;
            int el;
            bit lvl;
            if (rst) begin
                m_half[c] <= def_lim[c] + 1;
                m_el[c]   <= 0;
                m_lvl[c]  <= 1'b0;
                m_tick[c] <= 1'b0;
                m_pv[c]   <= 1'b0;
            end else begin
                nxt_half = load[c] ? int'(load_value) + 1 : (m_pv[c] ? m_pend[c] + 1 : m_half[c]);
                el  = m_el[c];
                lvl = m_lvl[c];
                if (restart[c]) begin
                    el = 0;
                    lvl = 1'b0;
                    m_half[c] <= nxt_half;
                    m_pv[c]   <= 1'b0;
                end else begin
                    if (enable[c]) el = el + 1;
                    if (enable[c] && el == m_half[c]) begin
                        el = 0;
                        lvl = !lvl;
                        m_half[c] <= nxt_half;
                        m_pv[c]   <= 1'b0;
                    end else if (load[c]) begin
                        m_pend[c] <= int'(load_value);
                        m_pv[c]   <= 1'b1;
                    end
                end
                m_tick[c] <= lvl && !m_lvl[c];
                m_el[c]   <= el;
                m_lvl[c]  <= lvl;
            end
        end
        if (rst) model_valid <= 1'b1;
    end

    always @(negedge clk) begin
        if (model_valid) begin
            for (int c = 0; c < NCH; c++) begin
                chk($sformatf("model clk_out[%0d]", c), int'(clk_out[c]), int'(m_lvl[c]));
                chk($sformatf("model tick[%0d]", c), int'(tick[c]), int'(m_tick[c]));
            end
        end
    end

    // Counts falling edges until clk_out[ch] changes; saturates at maxc on timeout.
    task automatic edges_to_change(input int ch, input int maxc, output int n);
        logic start;
        start = clk_out[ch];
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (clk_out[ch] == start && n < maxc);
    endtask

    initial begin
        int n;
        rst = 1'b1;
        enable = 3'b111;
        restart = '0;
        load = '0;
        load_value = '0;

        // 1. reset and free-running periods 2/4/8
        repeat (3) begin
            @(negedge clk);
            chk("reset clk_out", int'(clk_out), 0);
            chk("reset tick", int'(tick), 0);
        end
        rst = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            chk("free ch0 level", int'(clk_out[0]), k % 2);
            chk("free ch1 level", int'(clk_out[1]), (k / 2) % 2);
            chk("free ch2 level", int'(clk_out[2]), (k / 4) % 2);
            chk("free ch2 tick", int'(tick[2]), int'(k % 8 == 4));
            chk("free ch1 tick", int'(tick[1]), int'(k % 4 == 2));
        end

        // 2. freeze ch2 at count 2 for 5 cycles
        repeat (2) @(negedge clk);
        enable[2] = 1'b0;
        repeat (5) begin
            @(negedge clk);
            chk("frozen ch2 level", int'(clk_out[2]), 0);
            chk("frozen ch2 tick", int'(tick[2]), 0);
        end
        enable[2] = 1'b1;
        edges_to_change(2, 20, n);
        chk("resume ch2 rise delay", n, 2);
        chk("resume ch2 tick", int'(tick[2]), 1);

        // 3. ch1 restart while high, then restart while disabled
        n = 0;
        while (clk_out[1] != 1'b1 && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("ch1 high before restart", int'(clk_out[1]), 1);
        restart[1] = 1'b1;
        @(negedge clk);
        restart[1] = 1'b0;
        chk("restart ch1 level", int'(clk_out[1]), 0);
        chk("restart ch1 tick", int'(tick[1]), 0);
        edges_to_change(1, 20, n);
        chk("restart ch1 rise delay", n, 2);
        enable[1] = 1'b0;
        restart[1] = 1'b1;
        @(negedge clk);
        restart[1] = 1'b0;
        chk("disabled restart ch1 level", int'(clk_out[1]), 0);
        @(negedge clk);
        chk("disabled ch1 held", int'(clk_out[1]), 0);
        enable[1] = 1'b1;
        edges_to_change(1, 20, n);
        chk("reenable ch1 rise delay", n, 2);

        // 4. ch0 pending loads: newest wins, takes effect at next wrap
        enable[0] = 1'b0;
        load[0] = 1'b1;
        load_value = 8'd5;
        @(negedge clk);
        load_value = 8'd7;
        @(negedge clk);
        load[0] = 1'b0;
        enable[0] = 1'b1;
        edges_to_change(0, 20, n);
        chk("ch0 last old half-period", n, 1);
        load[0] = 1'b1;
        load_value = 8'd5;
        @(negedge clk);
        load[0] = 1'b0;
        edges_to_change(0, 20, n);
        chk("ch0 half-period 8 (rest)", n, 7);
        edges_to_change(0, 20, n);
        chk("ch0 half-period 6", n, 6);

        // 5. ch2 load coinciding with wrap, then load coinciding with restart
        n = 0;
        while (m_el[2] + 1 != m_half[2] && n < 20) begin
            @(negedge clk);
            n++;
        end
        load[2] = 1'b1;
        load_value = 8'd2;
        @(negedge clk);
        load[2] = 1'b0;
        edges_to_change(2, 20, n);
        chk("ch2 half-period after load+wrap", n, 3);
        restart[2] = 1'b1;
        load[2] = 1'b1;
        load_value = 8'd4;
        @(negedge clk);
        restart[2] = 1'b0;
        load[2] = 1'b0;
        chk("ch2 load+restart level", int'(clk_out[2]), 0);
        edges_to_change(2, 20, n);
        chk("ch2 rise after load+restart", n, 5);

        // 6. reset discards a pending limit on ch1
        n = 0;
        while (m_el[1] + 1 == m_half[1] && n < 10) begin
            @(negedge clk);
            n++;
        end
        load[1] = 1'b1;
        load_value = 8'd9;
        @(negedge clk);
        load[1] = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("ch1 after reset", int'(clk_out[1]), 0);
        for (int k = 0; k < 3; k++) begin
            edges_to_change(1, 20, n);
            chk("ch1 default half-period after reset", n, 2);
        end

        // Random traffic against the model
        for (int k = 0; k < 3000; k++) begin
            @(negedge clk);
            for (int c = 0; c < NCH; c++) begin
                enable[c]  = ($urandom_range(0, 9) != 0);
                restart[c] = ($urandom_range(0, 39) == 0);
                load[c]    = ($urandom_range(0, 19) == 0);
            end
            load_value = 8'($urandom_range(0, 6));
            rst = ($urandom_range(0, 299) == 0);
        end
        @(negedge clk);
        rst = 1'b0;
        enable = '0;
        restart = '0;
        load = '0;
        repeat (2) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
